// File: rtl/wdma_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : wdma_burst_tracker
// Purpose  : Write-DMA burst bookkeeping. Queues the length of every issued
//            AW burst, sequences W beats against the head entry and drives
//            WLAST, then counts bursts awaiting their B response. AW issue is
//            throttled so that queued plus B-pending bursts never exceed the
//            queue depth.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            aw_len, aw_fire            - length-1 and handshake of issued AW
//            aw_fifo_full_n             - high when another AW may be issued
//            wdata_valid, wdata_ready   - write DMA data beat handshake
//            m_axi_wvalid/wready/wlast  - AXI W channel control
//            m_axi_bvalid/bready/bresp  - AXI B channel
//            bresp_err                  - sticky non-OKAY response flag
//            b_pending                  - bursts with data done, B outstanding
//            idle                       - nothing queued and no B outstanding
// Revision : 1.0 - initial release
// ============================================================================
module wdma_burst_tracker #(
  parameter int LEN_W     = 4,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_W-1:0]     aw_len,
  input  logic                 aw_fire,
  output logic                 aw_fifo_full_n,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  output logic                 m_axi_wlast,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  input  logic [1:0]           m_axi_bresp,
  output logic                 bresp_err,
  output logic [DEPTH_LOG:0]   b_pending,
  output logic                 idle
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG+1:0] C_DEPTH = (DEPTH_LOG+2)'(DEPTH);

  logic [LEN_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG:0] r_wr_ptr;
  logic [DEPTH_LOG:0] r_rd_ptr;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [DEPTH_LOG:0] r_b_pending;
  logic               r_bresp_err;

  logic               w_empty;
  logic [DEPTH_LOG:0] w_q_count;
  logic [DEPTH_LOG+1:0] w_inflight;
  logic [LEN_W-1:0]   w_head_len;
  logic               w_push;
  logic               w_beat;
  logic               w_pop;
  logic               w_b_hs;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_q_count  = r_wr_ptr - r_rd_ptr;
  // Queued bursts plus bursts still owed a B; widened so the sum cannot wrap.
  assign w_inflight = {1'b0, w_q_count} + {1'b0, r_b_pending};
  assign w_head_len = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];

  assign aw_fifo_full_n = (w_inflight < C_DEPTH);
  assign m_axi_wvalid   = wdata_valid && !w_empty;
  assign wdata_ready    = m_axi_wready && !w_empty;
  assign m_axi_wlast    = !w_empty && (r_beat_cnt == w_head_len);
  assign m_axi_bready   = (r_b_pending != '0);
  assign b_pending      = r_b_pending;
  assign bresp_err      = r_bresp_err;
  assign idle           = w_empty && (r_b_pending == '0);

  assign w_push = aw_fire && aw_fifo_full_n;
  assign w_beat = m_axi_wvalid && m_axi_wready;
  assign w_pop  = w_beat && m_axi_wlast;
  assign w_b_hs = m_axi_bvalid && m_axi_bready;

  // Queue storage is not reset; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= aw_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_b_pending <= '0;
      r_bresp_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (DEPTH_LOG+1)'(1);
      end

      if (w_beat) begin
        if (m_axi_wlast) begin
          r_beat_cnt <= '0;
          r_rd_ptr   <= r_rd_ptr + (DEPTH_LOG+1)'(1);
        end else begin
          r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        end
      end

      // A completed burst and a returned B in the same cycle cancel out.
      case ({w_pop, w_b_hs})
        2'b10:   r_b_pending <= r_b_pending + (DEPTH_LOG+1)'(1);
        2'b01:   r_b_pending <= r_b_pending - (DEPTH_LOG+1)'(1);
        default: r_b_pending <= r_b_pending;
      endcase

      if (w_b_hs && (m_axi_bresp != 2'b00)) begin
        r_bresp_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wdma_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdma_burst_tracker
// Purpose  : Self-checking bench for wdma_burst_tracker against a queue-based
//            behavioural model of the burst bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdma_burst_tracker;

  localparam int LEN_W     = 4;
  localparam int DEPTH_LOG = 3;
  localparam int DEPTH     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [LEN_W-1:0]     aw_len;
  logic                 aw_fire;
  logic                 aw_fifo_full_n;
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic                 m_axi_wvalid;
  logic                 m_axi_wready;
  logic                 m_axi_wlast;
  logic                 m_axi_bvalid;
  logic                 m_axi_bready;
  logic [1:0]           m_axi_bresp;
  logic                 bresp_err;
  logic [DEPTH_LOG:0]   b_pending;
  logic                 idle;

  wdma_burst_tracker #(.LEN_W(LEN_W), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .aw_len         (aw_len),
    .aw_fire        (aw_fire),
    .aw_fifo_full_n (aw_fifo_full_n),
    .wdata_valid    (wdata_valid),
    .wdata_ready    (wdata_ready),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .m_axi_bresp    (m_axi_bresp),
    .bresp_err      (bresp_err),
    .b_pending      (b_pending),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: list of outstanding burst lengths, beats sent of head,
  // number of bursts awaiting B, sticky error.
  int mq[$];
  int m_beats;
  int m_bpend;
  bit m_err;

  function automatic bit exp_full_n();
    return (mq.size() + m_bpend) < DEPTH;
  endfunction

  function automatic bit exp_wlast();
    return (mq.size() > 0) && (m_beats == mq[0]);
  endfunction

  function automatic bit exp_idle();
    return (mq.size() == 0) && (m_bpend == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_beats = 0;
    m_bpend = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    bit push;
    bit whs;
    bit bhs;
    push = aw_fire && exp_full_n();
    whs  = wdata_valid && m_axi_wready && (mq.size() > 0);
    bhs  = m_axi_bvalid && (m_bpend > 0);
    if (whs) begin
      if (m_beats == mq[0]) begin
        void'(mq.pop_front());
        m_beats = 0;
        m_bpend++;
      end else begin
        m_beats++;
      end
    end
    if (bhs) begin
      m_bpend--;
      if (m_axi_bresp != 2'b00) m_err = 1'b1;
    end
    if (push) mq.push_back(int'(aw_len));
  endtask

  // Advance one clock: model consumes current inputs, then land 1ns past edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    aw_fire      = 1'b0;
    aw_len       = '0;
    wdata_valid  = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
  endtask

  task automatic drain();
    aw_fire      = 1'b0;
    wdata_valid  = 1'b1;
    m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b00;
    for (int i = 0; i < 100 && !exp_idle(); i++) tick();
    if (!exp_idle()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: model still busy after 100 cycles");
    end
    quiet();
    #1;
  endtask

  task automatic test_reset();
    wdata_valid  = 1'b1;
    m_axi_wready = 1'b1;
    #1;
    checks++; if (aw_fifo_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n: got %b want 1", aw_fifo_full_n); end
    checks++; if (m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b want 0", m_axi_wvalid); end
    checks++; if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", wdata_ready); end
    checks++; if (m_axi_wlast !== 1'b0) begin errors++; $display("FAIL reset_wlast: got %b want 0", m_axi_wlast); end
    checks++; if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", m_axi_bready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL reset_bpend: got %0d want 0", b_pending); end
    checks++; if (bresp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bresp_err); end
    quiet();
    tick();
  endtask

  task automatic test_single_bursts();
    int lens[3];
    int last_at[$];
    int beat_no;
    lens[0] = 0; lens[1] = 3; lens[2] = 15;
    beat_no = 0;
    wdata_valid  = 1'b1;
    m_axi_wready = 1'b1;
    for (int cyc = 0; cyc < 40 && last_at.size() < 3; cyc++) begin
      aw_fire = (cyc < 3);
      aw_len  = (cyc < 3) ? LEN_W'(lens[cyc]) : '0;
      #1;
      checks++; if (m_axi_wlast !== exp_wlast()) begin errors++; $display("FAIL single_wlast: cyc %0d got %b want %b", cyc, m_axi_wlast, exp_wlast()); end
      if (m_axi_wvalid && m_axi_wready) begin
        beat_no++;
        if (m_axi_wlast) last_at.push_back(beat_no);
      end
      tick();
    end
    aw_fire = 1'b0;
    wdata_valid = 1'b0;
    #1;
    checks++;
    if (last_at.size() != 3 || last_at[0] != 1 || last_at[1] != 5 || last_at[2] != 21) begin
      errors++;
      $display("FAIL single_wlast_pos: got %p want '{1,5,21}", last_at);
    end
    checks++; if (b_pending !== 4'd3) begin errors++; $display("FAIL single_bpend: got %0d want 3", b_pending); end
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = 2'b00;
    repeat (3) tick();
    m_axi_bvalid = 1'b0;
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
    drain();
  endtask

  task automatic test_full_throttle();
    quiet();
    for (int i = 0; i < DEPTH; i++) begin
      aw_fire = 1'b1;
      aw_len  = 4'd1;
      #1;
      checks++; if (aw_fifo_full_n !== 1'b1) begin errors++; $display("FAIL full_early: push %0d got %b want 1", i, aw_fifo_full_n); end
      tick();
    end
    aw_len = 4'd5;
    #1;
    checks++; if (aw_fifo_full_n !== 1'b0) begin errors++; $display("FAIL full_after8: got %b want 0", aw_fifo_full_n); end
    tick();
    aw_fire      = 1'b0;
    wdata_valid  = 1'b1;
    m_axi_wready = 1'b1;
    repeat (2 * DEPTH) tick();
    aw_fire = 1'b1;
    tick();
    aw_fire = 1'b0;
    #1;
    checks++; if (m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL full_ignored_push: wvalid got %b want 0", m_axi_wvalid); end
    checks++; if (b_pending !== 4'd8) begin errors++; $display("FAIL full_bpend: got %0d want 8", b_pending); end
    checks++; if (aw_fifo_full_n !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", aw_fifo_full_n); end
    m_axi_bvalid = 1'b1;
    #1;
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL full_bready: got %b want 1", m_axi_bready); end
    tick();
    m_axi_bvalid = 1'b0;
    #1;
    checks++; if (aw_fifo_full_n !== 1'b1) begin errors++; $display("FAIL full_release: got %b want 1", aw_fifo_full_n); end
    checks++; if (b_pending !== 4'd7) begin errors++; $display("FAIL full_bpend7: got %0d want 7", b_pending); end
    drain();
  endtask

  task automatic test_pointer_wrap();
    int pushed;
    int completed;
    int beat;
    pushed = 0; completed = 0; beat = 0;
    for (int cyc = 0; cyc < 3000 && !(pushed == 20 && exp_idle()); cyc++) begin
      aw_fire      = (pushed < 20) && ($urandom_range(0, 1) == 1);
      aw_len       = 4'd2;
      wdata_valid  = ($urandom_range(0, 3) != 0);
      m_axi_wready = ($urandom_range(0, 1) == 1);
      m_axi_bvalid = ($urandom_range(0, 1) == 1);
      m_axi_bresp  = 2'b00;
      #1;
      checks++; if (m_axi_wvalid !== (wdata_valid && mq.size() > 0)) begin errors++; $display("FAIL wrap_wvalid: cyc %0d got %b", cyc, m_axi_wvalid); end
      checks++; if (m_axi_wlast !== exp_wlast()) begin errors++; $display("FAIL wrap_wlast: cyc %0d got %b want %b", cyc, m_axi_wlast, exp_wlast()); end
      checks++; if (aw_fifo_full_n !== exp_full_n()) begin errors++; $display("FAIL wrap_full_n: cyc %0d got %b want %b", cyc, aw_fifo_full_n, exp_full_n()); end
      checks++; if (int'(b_pending) != m_bpend) begin errors++; $display("FAIL wrap_bpend: cyc %0d got %0d want %0d", cyc, b_pending, m_bpend); end
      if (aw_fire && exp_full_n()) pushed++;
      if (m_axi_wvalid && m_axi_wready) begin
        beat++;
        if (m_axi_wlast) begin
          checks++; if (beat != 3) begin errors++; $display("FAIL wrap_last_beat: got beat %0d want 3", beat); end
          beat = 0;
          completed++;
        end
      end
      tick();
    end
    quiet();
    #1;
    checks++; if (completed != 20) begin errors++; $display("FAIL wrap_count: got %0d bursts want 20", completed); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL wrap_idle: got %b want 1", idle); end
    drain();
  endtask

  task automatic test_simultaneous();
    quiet();
    aw_fire = 1'b1; aw_len = 4'd0;
    tick();
    // Push B while A's only beat pops.
    wdata_valid = 1'b1; m_axi_wready = 1'b1;
    #1;
    checks++; if (m_axi_wlast !== 1'b1) begin errors++; $display("FAIL simul_wlast_a: got %b want 1", m_axi_wlast); end
    tick();
    // Push C (len 1), pop B, and return A's B in the same cycle.
    aw_len = 4'd1;
    m_axi_bvalid = 1'b1;
    #1;
    checks++; if (m_axi_wvalid !== 1'b1) begin errors++; $display("FAIL simul_q_kept: wvalid got %b want 1", m_axi_wvalid); end
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL simul_bpend_a: got %0d want 1", b_pending); end
    tick();
    aw_fire = 1'b0; m_axi_bvalid = 1'b0; wdata_valid = 1'b0;
    #1;
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL simul_bpend_hold: got %0d want 1", b_pending); end
    checks++; if (m_axi_wlast !== 1'b0) begin errors++; $display("FAIL simul_wlast_c: got %b want 0", m_axi_wlast); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b want 0", idle); end
    drain();
  endtask

  task automatic test_error_stray();
    quiet();
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    #1;
    checks++; if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL stray_bready: got %b want 0", m_axi_bready); end
    tick();
    m_axi_bvalid = 1'b0;
    #1;
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL stray_bpend: got %0d want 0", b_pending); end
    checks++; if (bresp_err !== 1'b0) begin errors++; $display("FAIL stray_err: got %b want 0", bresp_err); end
    aw_fire = 1'b1; aw_len = 4'd0;
    tick();
    aw_fire = 1'b0; wdata_valid = 1'b1; m_axi_wready = 1'b1;
    tick();
    wdata_valid = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #1;
    checks++; if (bresp_err !== m_err) begin errors++; $display("FAIL err_set: got %b want %b", bresp_err, m_err); end
    drain();
    aw_fire = 1'b1; aw_len = 4'd1;
    tick();
    drain();
    checks++; if (bresp_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bresp_err); end
  endtask

  task automatic test_reset_mid_burst();
    quiet();
    aw_fire = 1'b1; aw_len = 4'd3;
    tick();
    aw_fire = 1'b0; wdata_valid = 1'b1; m_axi_wready = 1'b1;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_wvalid: got %b want 0", m_axi_wvalid); end
    checks++; if (b_pending !== 4'd0) begin errors++; $display("FAIL rst_mid_bpend: got %0d want 0", b_pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b want 1", idle); end
    checks++; if (aw_fifo_full_n !== 1'b1) begin errors++; $display("FAIL rst_mid_full_n: got %b want 1", aw_fifo_full_n); end
    checks++; if (bresp_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %b want 0", bresp_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    aw_fire = 1'b1; aw_len = 4'd0;
    tick();
    aw_fire = 1'b0;
    #1;
    checks++; if (m_axi_wlast !== 1'b1) begin errors++; $display("FAIL rst_new_wlast: got %b want 1", m_axi_wlast); end
    checks++; if (m_axi_wvalid !== 1'b1) begin errors++; $display("FAIL rst_new_wvalid: got %b want 1", m_axi_wvalid); end
    tick();
    wdata_valid = 1'b0;
    #1;
    checks++; if (b_pending !== 4'd1) begin errors++; $display("FAIL rst_new_bpend: got %0d want 1", b_pending); end
    drain();
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_single_bursts();
    test_full_throttle();
    test_pointer_wrap();
    test_simultaneous();
    test_error_stray();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wdma_burst_tracker.md
Name: wdma_burst_tracker

Overview:
- Write-side companion to the read DMA's AR-length FIFO.
- Records the burst length of every issued AXI write address (AW), sequences the W channel beats for each burst, generates WLAST, and tracks outstanding B responses.
- Sits between the write DMA's AW issuer and its W/B channel logic; throttles AW issue so that in-flight bursts never exceed the queue depth.

Parameters:
- LEN_W, 4, width of the AXI burst length field (beats minus 1).
- DEPTH_LOG, 3, log2 of the burst queue depth; depth = 2^DEPTH_LOG = 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- aw_len  in  LEN_W  burst length minus 1 of the AW being issued.
- aw_fire  in  1  AW handshake (awvalid && awready) this cycle.
- aw_fifo_full_n  out  1  high = another AW may be issued.
- wdata_valid  in  1  write DMA has a data beat.
- wdata_ready  out  1  beat accepted this cycle.
- m_axi_wvalid  out  1  AXI W valid.
- m_axi_wready  in  1  AXI W ready.
- m_axi_wlast  out  1  AXI W last.
- m_axi_bvalid  in  1  AXI B valid.
- m_axi_bready  out  1  AXI B ready.
- m_axi_bresp  in  2  AXI B response.
- bresp_err  out  1  sticky: some B response was non-OKAY.
- b_pending  out  DEPTH_LOG+1  bursts whose data is complete but whose B is not yet received.
- idle  out  1  no queued bursts and no pending B.

Behaviour:
- Reset (async assert, sync release at clk edge): read/write pointers = 0, beat counter = 0, b_pending = 0, bresp_err = 0. Queue storage need not be reset.
- Reset output values: aw_fifo_full_n = 1, m_axi_wvalid = 0, wdata_ready = 0, m_axi_wlast = 0, m_axi_bready = 0, idle = 1.
- Queue:
  - 2^DEPTH_LOG entries of LEN_W bits.
  - Pointers are DEPTH_LOG+1 bits.
  - empty = equal pointers; wrap indicated by MSB difference.
  - q_count = wr_ptr - rd_ptr (modulo 2^(DEPTH_LOG+1)).
- Push:
  - Occurs on aw_fire && aw_fifo_full_n; writes aw_len at wr_ptr; wr_ptr + 1.
  - aw_fire while aw_fifo_full_n = 0 is ignored: no push, no pointer change.
  - An entry pushed into an empty queue is visible as head on the next cycle.
- aw_fifo_full_n = (q_count + b_pending) < 2^DEPTH_LOG. This caps total in-flight bursts (queued plus awaiting B) at the queue depth.
- W gating (combinational):
  - m_axi_wvalid = wdata_valid && !empty.
  - wdata_ready = m_axi_wready && !empty.
  - m_axi_wlast = !empty && (beat_cnt == head_len).
- Beat handshake = m_axi_wvalid && m_axi_wready.
  - Not last: beat_cnt + 1.
  - Last: beat_cnt <- 0, rd_ptr + 1 (pop), b_pending + 1.
- Burst of head_len = 0: a single beat carries WLAST.
- B channel:
  - m_axi_bready = (b_pending != 0).
  - B handshake: b_pending - 1; if m_axi_bresp != 2'b00, bresp_err <- 1.
  - bresp_err clears only on reset.
  - bvalid while b_pending = 0 is not acknowledged and causes no state change.
- Simultaneous events:
  - Push and pop in the same cycle: both take effect; q_count unchanged.
  - Last-beat pop and B handshake in the same cycle: b_pending unchanged.
  - Push while full_n recomputes: full_n reflects registered state only; no same-cycle bypass.
- idle = empty && (b_pending == 0).
- Latency: AW push to first beat eligibility is 1 cycle. WLAST is combinational on the head entry.
- No state machine beyond the counters; the beat counter is the only per-burst state.

Test Plan:
- Reset mid-burst: push len 3, send 2 beats, assert rst_n = 0 asynchronously → immediately wvalid = 0, b_pending = 0, idle = 1, full_n = 1. After release, a new push of len 0 yields a single-beat WLAST.
- Single bursts: push lens 0, 3, 15 back-to-back with wready held high → WLAST on beats 1, 5 (4th of the 2nd burst), and 21 (16th of the 3rd burst); b_pending reaches 3; three OKAY B responses return idle to 1.
- Full/throttle: push 8 bursts of len 1 with no W traffic → full_n = 0 after the 8th. Complete all W beats with no B → full_n stays 0 (b_pending = 8). One B handshake → full_n = 1 on the next cycle. A 9th aw_fire attempted while full is ignored.
- Pointer wrap: 20 bursts of len 2, random wready/bvalid, ≤ 8 in flight → every WLAST on the 3rd beat, no lost or duplicated burst, final idle = 1.
- Simultaneous events: push while the last beat of the head burst completes (q_count unchanged); a B handshake in the same cycle as a last-beat pop (b_pending unchanged).
- Error and stray response: a B with bresp = 2'b10 → bresp_err = 1 and it stays set. bvalid with b_pending = 0 → bready = 0 and the count is unaffected.
